// File: rtl/mesh_out_arbiter.sv
// mesh_out_arbiter: round-robin arbiter sharing one outgoing mesh link among
// N_REQ requesters (index 0 = local inject, 1..8 = transit inputs).
// The winning flit is registered onto the link one cycle after its grant.
// Optional feature macro: MESH_ARB_CREDIT_EN builds the downstream credit
// counter and the sticky cred_err flag. Without it the link is treated as
// always able to accept, credit_ret is ignored and cred_err is tied low.
//
// Handshake (valid/ready): a requester raises req_valid[i] with its flit on
// req_flit[i*FLIT_W +: FLIT_W]. req_ready[i] is a combinational, one-hot-or-
// zero grant. A transfer happens on a rising edge where req_valid[i] &&
// req_ready[i]. The requester holds flit and valid until granted. It may
// drop valid before the grant, which withdraws the request.
module mesh_out_arbiter #(
    parameter int N_REQ   = 9,
    parameter int FLIT_W  = 34,
    parameter int CREDITS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*FLIT_W-1:0] req_flit,
    output logic [N_REQ-1:0]        req_ready,
    input  logic                    credit_ret,
    input  logic                    stat_clr,
    output logic [FLIT_W-1:0]       out_flit,
    output logic                    out_valid,
    output logic [3:0]              grant_idx,
    output logic [15:0]             conflict_cnt,
    output logic                    cred_err
);

    logic [3:0]        ptr;
    logic [3:0]        winner;
    logic              found;
    logic              can_send;
    logic              xfer;
    logic              contended;
    logic [FLIT_W-1:0] win_flit;

    // Round-robin scan: first valid requester at or after ptr, wrapping.
    always_comb begin
        logic [4:0] sum;
        logic [3:0] idx;
        found  = 1'b0;
        winner = '0;
        sum    = '0;
        idx    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            sum = 5'(ptr) + 5'(k);
            if (sum >= 5'(N_REQ)) begin
                sum = sum - 5'(N_REQ);
            end
            idx = sum[3:0];
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    // One-hot grant to the winner; nothing is granted while in reset.
    always_comb begin
        req_ready = '0;
        if (rst_n && can_send && found) begin
            req_ready[winner] = 1'b1;
        end
    end

    assign xfer      = |(req_valid & req_ready);
    // More than one requester eligible: clearing the lowest set bit leaves bits.
    assign contended = |(req_valid & (req_valid - N_REQ'(1)));

    // Select the winning requester's flit.
    always_comb begin
        win_flit = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (winner == 4'(i)) begin
                win_flit = req_flit[i*FLIT_W +: FLIT_W];
            end
        end
    end

    // Link register, last-winner index and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_flit  <= '0;
            out_valid <= 1'b0;
            grant_idx <= '0;
            ptr       <= '0;
        end else if (xfer) begin
            out_flit  <= win_flit;
            out_valid <= 1'b1;
            grant_idx <= winner;
            ptr       <= (winner == 4'(N_REQ-1)) ? 4'd0 : winner + 4'd1;
        end else begin
            out_flit  <= '0;
            out_valid <= 1'b0;
        end
    end

    // Saturating count of transfers made while requesters were competing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict_cnt <= '0;
        end else if (stat_clr) begin
            conflict_cnt <= '0;
        end else if (xfer && contended && (conflict_cnt != 16'hFFFF)) begin
            conflict_cnt <= conflict_cnt + 16'd1;
        end
    end

`ifdef MESH_ARB_CREDIT_EN
    logic [3:0] cnt;

    // Downstream credit meter; a return with the counter full is flagged, not counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= 4'(CREDITS);
            cred_err <= 1'b0;
        end else if (xfer && !credit_ret) begin
            cnt <= cnt - 4'd1;
        end else if (!xfer && credit_ret) begin
            if (cnt == 4'(CREDITS)) begin
                cred_err <= 1'b1;
            end else begin
                cnt <= cnt + 4'd1;
            end
        end
    end

    assign can_send = (cnt != 4'd0);
`else
    logic unused_credit_ret;

    assign unused_credit_ret = credit_ret;
    assign can_send          = 1'b1;
    assign cred_err          = 1'b0;
`endif

endmodule

// File: tb/tb_mesh_out_arbiter.sv
// tb_mesh_out_arbiter: directed and randomized bench for mesh_out_arbiter.
// A behavioural model picks the winner as the valid requester closest to the
// pointer in round-robin distance and tracks credits, statistics and the
// link contents (expected-flit queue).
module tb_mesh_out_arbiter;

    localparam int N = 9;
    localparam int W = 34;
    localparam int CREDITS = 4;
`ifdef MESH_ARB_CREDIT_EN
    localparam bit CREDIT_EN = 1'b1;
`else
    localparam bit CREDIT_EN = 1'b0;
`endif

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_flit;
    logic [N-1:0]   req_ready;
    logic           credit_ret;
    logic           stat_clr;
    logic [W-1:0]   out_flit;
    logic           out_valid;
    logic [3:0]     grant_idx;
    logic [15:0]    conflict_cnt;
    logic           cred_err;

    mesh_out_arbiter #(.N_REQ(N), .FLIT_W(W), .CREDITS(CREDITS)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_flit(req_flit), .req_ready(req_ready),
        .credit_ret(credit_ret), .stat_clr(stat_clr),
        .out_flit(out_flit), .out_valid(out_valid), .grant_idx(grant_idx),
        .conflict_cnt(conflict_cnt), .cred_err(cred_err)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // model state
    logic [W-1:0] flit_a [N];
    logic [W-1:0] exp_q [$];
    int           m_ptr, m_cnt, m_conf, m_gidx;
    bit           m_err;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] rand_flit();
        return {1'b1, 1'($urandom_range(0, 1)), 32'($urandom)};
    endfunction

    function automatic void model_reset();
        m_ptr  = 0;
        m_cnt  = CREDITS;
        m_conf = 0;
        m_gidx = 0;
        m_err  = 1'b0;
        exp_q.delete();
    endfunction

    // Valid requester with the smallest round-robin distance from the pointer.
    function automatic int model_winner();
        int best, bestd, d;
        best  = -1;
        bestd = N;
        for (int i = 0; i < N; i++) begin
            d = (i - m_ptr + N) % N;
            if (req_valid[i] && d < bestd) begin
                best  = i;
                bestd = d;
            end
        end
        return best;
    endfunction

    task automatic pack();
        for (int i = 0; i < N; i++) req_flit[i*W +: W] = flit_a[i];
    endtask

    // driver: one clock cycle with the currently driven inputs
    task automatic step(input bit chk, output int won);
        int           w, nv;
        bit           can, xfer;
        logic [N-1:0] exp_ready;
        logic [W-1:0] exp_flit;
        pack();
        @(negedge clk);
        can  = CREDIT_EN ? (m_cnt != 0) : 1'b1;
        w    = model_winner();
        xfer = can && (w >= 0);
        exp_ready = '0;
        if (xfer) exp_ready[w] = 1'b1;
        if (chk) check("req_ready", 64'(req_ready), 64'(exp_ready));
        nv = $countones(req_valid);
        if (xfer) begin
            exp_q.push_back(flit_a[w]);
            m_gidx = w;
            m_ptr  = (w + 1) % N;
        end
        if (stat_clr) m_conf = 0;
        else if (xfer && nv >= 2 && m_conf < 65535) m_conf++;
        if (CREDIT_EN) begin
            if (xfer && !credit_ret) m_cnt--;
            else if (!xfer && credit_ret) begin
                if (m_cnt == CREDITS) m_err = 1'b1;
                else m_cnt++;
            end
        end
        @(posedge clk);
        #1;
        exp_flit = '0;
        if (xfer) exp_flit = exp_q.pop_front();
        if (chk) begin
            check("out_valid", 64'(out_valid), 64'(xfer));
            check("out_flit", 64'(out_flit), 64'(exp_flit));
            check("grant_idx", 64'(grant_idx), 64'(m_gidx));
            check("conflict_cnt", 64'(conflict_cnt), 64'(m_conf));
            check("cred_err", 64'(cred_err), 64'(m_err));
        end
        if (xfer) flit_a[w] = rand_flit();
        won = xfer ? w : -1;
    endtask

    // Asynchronous reset pulse; called at posedge+1.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_flit", 64'(out_flit), 64'd0);
        check("rst_grant_idx", 64'(grant_idx), 64'd0);
        check("rst_conflict", 64'(conflict_cnt), 64'd0);
        check("rst_cred_err", 64'(cred_err), 64'd0);
        model_reset();
        pack();
        @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    localparam logic [W-1:0] BASE = 34'h2_0000_0001;

    initial begin
        int won, seq, ngrant;
        rst_n      = 1'b0;
        req_valid  = '1;
        credit_ret = 1'b0;
        stat_clr   = 1'b0;
        for (int i = 0; i < N; i++) flit_a[i] = rand_flit();
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // Round-robin fairness: all valid, a credit returned every cycle.
        credit_ret = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step(1'b1, won);
            check("rr_order", 64'(grant_idx), 64'(k % N));
        end
        check("rr_conflict10", 64'(conflict_cnt), 64'd10);

        // Wrap and skip: bring ptr to 7, then only 2 and 8 request.
        req_valid = 9'b0_0100_0000;
        step(1'b1, won);
        check("wrap_setup", 64'(grant_idx), 64'd6);
        req_valid = 9'b1_0000_0100;
        step(1'b1, won);
        check("wrap_first", 64'(grant_idx), 64'd8);
        step(1'b1, won);
        check("wrap_second", 64'(grant_idx), 64'd2);
        req_valid = 9'b0_0001_0010;
        step(1'b1, won);
        check("wrap_ptr3", 64'(grant_idx), 64'd4);

        // Randomized traffic against the model.
        for (int k = 0; k < 300; k++) begin
            req_valid  = N'($urandom_range(0, (1 << N) - 1));
            credit_ret = ($urandom_range(0, 2) == 0);
            stat_clr   = ($urandom_range(0, 19) == 0);
            step(1'b1, won);
        end
        stat_clr = 1'b0;

        // Reset mid-stream drops the link asynchronously.
        req_valid  = 9'b0_0000_1000;
        credit_ret = 1'b1;
        step(1'b1, won);
        check("pre_reset_valid", 64'(out_valid), 64'd1);
        do_reset();

        // Credit exhaustion: requester 3 streams with no returns.
        credit_ret = 1'b0;
        req_valid  = 9'b0_0000_1000;
        seq        = 0;
        ngrant     = 0;
        flit_a[3]  = BASE;
        for (int k = 0; k < 6; k++) begin
            step(1'b1, won);
            if (out_valid) begin
                check("stream_flit", 64'(out_flit), 64'(BASE + W'(seq)));
                ngrant++;
                seq++;
                flit_a[3] = BASE + W'(seq);
            end
        end
        check("stream_count", 64'(ngrant), CREDIT_EN ? 64'd4 : 64'd6);
        if (CREDIT_EN) begin
            credit_ret = 1'b1;
            step(1'b1, won);
            check("ret_same_cycle", 64'(out_valid), 64'd0);
            credit_ret = 1'b0;
            step(1'b1, won);
            check("ret_one_flit", 64'(out_valid), 64'd1);
            check("ret_flit_val", 64'(out_flit), 64'(BASE + W'(4)));
            step(1'b1, won);
            check("ret_then_stall", 64'(out_valid), 64'd0);
        end

        // Overflow flag and simultaneous grant + return.
        @(posedge clk);
        #1;
        do_reset();
        req_valid  = '0;
        credit_ret = 1'b1;
        step(1'b1, won);
        check("ovf_flag", 64'(cred_err), CREDIT_EN ? 64'd1 : 64'd0);
        credit_ret = 1'b0;
        step(1'b1, won);
        check("ovf_sticky", 64'(cred_err), CREDIT_EN ? 64'd1 : 64'd0);
        req_valid  = 9'b0_0010_0000;
        credit_ret = 1'b1;
        step(1'b1, won);
        credit_ret = 1'b0;
        ngrant = 0;
        for (int k = 0; k < 6; k++) begin
            step(1'b1, won);
            if (out_valid) ngrant++;
        end
        check("ovf_cnt_kept", 64'(ngrant), CREDIT_EN ? 64'd4 : 64'd6);

        // Statistics clear and saturation under full contention.
        @(posedge clk);
        #1;
        do_reset();
        req_valid  = '1;
        credit_ret = 1'b1;
        for (int k = 0; k < 3; k++) step(1'b1, won);
        stat_clr = 1'b1;
        step(1'b1, won);
        check("clr_contended", 64'(conflict_cnt), 64'd0);
        stat_clr = 1'b0;
        for (int k = 0; k < 65540; k++) step(1'b0, won);
        check("sat_ffff", 64'(conflict_cnt), 64'hFFFF);
        step(1'b1, won);
        check("sat_hold", 64'(conflict_cnt), 64'hFFFF);
        stat_clr = 1'b1;
        step(1'b1, won);
        check("sat_clear", 64'(conflict_cnt), 64'd0);
        stat_clr = 1'b0;
        check("exp_q_empty", 64'(exp_q.size()), 64'd0);

        // final report
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
